ex_mem_stage_elastic: RTL and testbench

- Parametrised EX→MEM pipeline boundary register with valid/ready handshaking, a two-entry skid buffer, and synchronous flush.
- Carries the ALU result, the store data, the destination register number and the control bits (wreg, m2reg, wmem, store-hazard) from EX to MEM.
- Unlike a plain per-cycle register, it can stall without losing data and can inject bubbles.
- Sits between the EX datapath and the MEM stage or data-memory interface.

---
 rtl/ex_mem_pkg.sv | 22 ++
 rtl/ex_mem_pipe_slot.sv | 56 +++++
 rtl/ex_mem_stage_elastic.sv | 174 +++++++++++++++++
 tb/tb_ex_mem_stage_elastic.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX->MEM elastic pipeline boundary.
package ex_mem_pkg;

  // Default payload widths
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned WN_W_DEF   = 5;
  localparam int unsigned CTRL_W_DEF = 4;

  // Bit positions inside the control vector
  localparam int unsigned CTRL_WREG  = 0;
  localparam int unsigned CTRL_M2REG = 1;
  localparam int unsigned CTRL_WMEM  = 2;
  localparam int unsigned CTRL_STHAZ = 3;

  // Occupancy-encoded stage state: the value equals the number of entries held
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/ex_mem_pipe_slot.sv
// One pipeline entry: valid + control + destination + ALU result + store data.
module ex_mem_pipe_slot
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned WN_W   = WN_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ld_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [WN_W-1:0]   wn_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] qb_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [WN_W-1:0]   wn_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] qb_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [WN_W-1:0]   wn_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] qb_q;

  // Clear invalidates and zeroes control only; payload keeps its last value
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      wn_q    <= '0;
      alu_q   <= '0;
      qb_q    <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      wn_q    <= wn_i;
      alu_q   <= alu_i;
      qb_q    <= qb_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign wn_o    = wn_q;
  assign alu_o   = alu_q;
  assign qb_o    = qb_q;

endmodule

// File: rtl/ex_mem_stage_elastic.sv
// EX->MEM boundary register with valid/ready handshake, optional skid entry and flush.
module ex_mem_stage_elastic
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned WN_W   = WN_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [WN_W-1:0]   in_wn,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_qb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [WN_W-1:0]   out_wn,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_di,
  output logic [1:0]        occupancy
);

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   in_xfer, out_xfer;
  logic   main_ld, main_clr, main_from_skid;
  logic   skid_ld, skid_clr;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [WN_W-1:0]   main_wn;
  logic [DATA_W-1:0] main_alu;
  logic [DATA_W-1:0] main_qb;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [WN_W-1:0]   skid_wn;
  logic [DATA_W-1:0] skid_alu;
  logic [DATA_W-1:0] skid_qb;

  logic [CTRL_W-1:0] main_ctrl_d;
  logic [WN_W-1:0]   main_wn_d;
  logic [DATA_W-1:0] main_alu_d;
  logic [DATA_W-1:0] main_qb_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  // Next-state and slot enables; flush overrides every transfer in its cycle
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (in_xfer) begin
            // Only reachable with the skid entry present: without it, in_ready implies out_ready
            skid_ld = 1'b1;
            state_d = TWO;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register and registered in_ready (low only when both entries are full)
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Main entry refills from the skid entry when draining, else from EX
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_wn_d   = main_from_skid ? skid_wn   : in_wn;
  assign main_alu_d  = main_from_skid ? skid_alu  : in_alu;
  assign main_qb_d   = main_from_skid ? skid_qb   : in_qb;

  ex_mem_pipe_slot #(
    .DATA_W (DATA_W),
    .WN_W   (WN_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .clrn    (clrn),
    .ld_i    (main_ld),
    .clr_i   (main_clr),
    .ctrl_i  (main_ctrl_d),
    .wn_i    (main_wn_d),
    .alu_i   (main_alu_d),
    .qb_i    (main_qb_d),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .wn_o    (main_wn),
    .alu_o   (main_alu),
    .qb_o    (main_qb)
  );

  if (SKID != 0) begin : g_skid
    ex_mem_pipe_slot #(
      .DATA_W (DATA_W),
      .WN_W   (WN_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk     (clk),
      .clrn    (clrn),
      .ld_i    (skid_ld),
      .clr_i   (skid_clr),
      .ctrl_i  (in_ctrl),
      .wn_i    (in_wn),
      .alu_i   (in_alu),
      .qb_i    (in_qb),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .wn_o    (skid_wn),
      .alu_o   (skid_alu),
      .qb_o    (skid_qb)
    );
    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_wn    = '0;
    assign skid_alu   = '0;
    assign skid_qb    = '0;
    assign in_ready   = out_ready | ~main_valid;
  end

  // Bubbles never carry live control bits
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_wn    = main_wn;
  assign out_alu   = main_alu;
  assign out_di    = main_qb;
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

endmodule

// File: tb/tb_ex_mem_stage_elastic.sv
// Self-checking bench: directed table, hand sequences and a queue-based reference model.
module tb_ex_mem_stage_elastic;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_ctrl = '0;
  logic [4:0]  in_wn = '0;
  logic [31:0] in_alu = '0;
  logic [31:0] in_qb = '0;

  logic        in_ready1, out_valid1;
  logic [3:0]  out_ctrl1;
  logic [4:0]  out_wn1;
  logic [31:0] out_alu1, out_di1;
  logic [1:0]  occ1;

  logic        in_ready0, out_valid0;
  logic [3:0]  out_ctrl0;
  logic [4:0]  out_wn0;
  logic [31:0] out_alu0, out_di0;
  logic [1:0]  occ0;

  ex_mem_stage_elastic #(.DATA_W(32), .WN_W(5), .CTRL_W(4), .SKID(1)) u_dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_wn(in_wn),
    .in_alu(in_alu), .in_qb(in_qb),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_wn(out_wn1),
    .out_alu(out_alu1), .out_di(out_di1), .occupancy(occ1)
  );

  ex_mem_stage_elastic #(.DATA_W(32), .WN_W(5), .CTRL_W(4), .SKID(0)) u_dut0 (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_wn(in_wn),
    .in_alu(in_alu), .in_qb(in_qb),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_wn(out_wn0),
    .out_alu(out_alu0), .out_di(out_di0), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef logic [79:0] vec_t;

  typedef struct packed {
    logic [3:0]  c;
    logic [4:0]  w;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic fl; logic iv; logic [3:0] c; logic [4:0] w; logic [31:0] a; logic [31:0] d; logic ordy;
    logic ev; logic [3:0] ec; logic [4:0] ew; logic [31:0] ea; logic [31:0] ed; logic [1:0] eo; logic er;
  } row_t;

  row_t tbl[12];
  ent_t q1[$];
  ent_t q0[$];
  ent_t last1, last0, h1, h0, e;
  logic rdy1, rdy0;

  function automatic vec_t pk(logic v, logic [3:0] c, logic [4:0] w, logic [31:0] a,
                              logic [31:0] d, logic [1:0] o, logic r);
    return {3'b000, v, c, w, a, d, o, r};
  endfunction

  function automatic vec_t act1();
    return pk(out_valid1, out_ctrl1, out_wn1, out_alu1, out_di1, occ1, in_ready1);
  endfunction

  function automatic vec_t act0();
    return pk(out_valid0, out_ctrl0, out_wn0, out_alu0, out_di0, occ0, in_ready0);
  endfunction

  // Expected outputs from queue depth, visible entry and expected in_ready
  function automatic vec_t exp_from(int sz, ent_t h, logic r);
    if (sz == 0) return pk(1'b0, 4'b0000, h.w, h.a, h.d, 2'd0, r);
    return pk(1'b1, h.c, h.w, h.a, h.d, 2'(sz), r);
  endfunction

  task automatic chk(string name, vec_t act, vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic iv, logic [3:0] c, logic [4:0] w,
                       logic [31:0] a, logic [31:0] d, logic ordy);
    flush = fl; in_valid = iv; in_ctrl = c; in_wn = w; in_alu = a; in_qb = d; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    step();
    q1.delete(); q0.delete();
    last1 = '0; last0 = '0;
  endtask

  initial begin
    // fl iv ctrl wn alu qb ordy | v ctrl wn alu di occ rdy
    tbl[0]  = '{0,1,4'b0101,5'd7,32'h0000_1234,32'hDEAD_BEEF,1, 1,4'b0101,5'd7,32'h0000_1234,32'hDEAD_BEEF,2'd1,1};
    tbl[1]  = '{0,0,4'h0,5'd0,32'h0,32'h0,1,                   0,4'h0,5'd7,32'h0000_1234,32'hDEAD_BEEF,2'd0,1};
    tbl[2]  = '{0,1,4'h1,5'd1,32'h11,32'hB1,0,                 1,4'h1,5'd1,32'h11,32'hB1,2'd1,1};
    tbl[3]  = '{0,1,4'h2,5'd2,32'h22,32'hB2,0,                 1,4'h1,5'd1,32'h11,32'hB1,2'd2,0};
    tbl[4]  = '{0,1,4'h4,5'd3,32'h33,32'hB3,0,                 1,4'h1,5'd1,32'h11,32'hB1,2'd2,0};
    tbl[5]  = '{0,1,4'h4,5'd3,32'h33,32'hB3,1,                 1,4'h2,5'd2,32'h22,32'hB2,2'd1,1};
    tbl[6]  = '{0,1,4'h4,5'd3,32'h33,32'hB3,1,                 1,4'h4,5'd3,32'h33,32'hB3,2'd1,1};
    tbl[7]  = '{0,0,4'h0,5'd0,32'h0,32'h0,1,                   0,4'h0,5'd3,32'h33,32'hB3,2'd0,1};
    tbl[8]  = '{0,1,4'h3,5'd4,32'hC1,32'hD1,0,                 1,4'h3,5'd4,32'hC1,32'hD1,2'd1,1};
    tbl[9]  = '{0,1,4'h8,5'd5,32'hC2,32'hD2,0,                 1,4'h3,5'd4,32'hC1,32'hD1,2'd2,0};
    tbl[10] = '{1,1,4'h5,5'd6,32'h55,32'h66,1,                 0,4'h0,5'd4,32'hC1,32'hD1,2'd0,1};
    tbl[11] = '{0,0,4'h0,5'd0,32'h0,32'h0,1,                   0,4'h0,5'd4,32'hC1,32'hD1,2'd0,1};

    // Power-on reset state
    #12;
    chk("reset_state", act1(), pk(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b1));
    chk("reset_state_noskid", act0(), pk(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b1));
    #1 clrn = 1'b1;

    // Load an entry, then drop clrn mid-cycle: outputs must clear without a clock edge
    step();
    drive(1'b0, 1'b1, 4'hF, 5'd31, 32'h99, 32'h98, 1'b0);
    step();
    chk("preload", act1(), pk(1'b1, 4'hF, 5'd31, 32'h99, 32'h98, 2'd1, 1'b1));
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    #3 clrn = 1'b0;
    #1;
    chk("async_reset", act1(), pk(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b1));
    #2 clrn = 1'b1;
    step();

    // Directed table: basic transfer, backpressure ordering, flush priority
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d", i), act1(),
          pk(tbl[i].ev, tbl[i].ec, tbl[i].ew, tbl[i].ea, tbl[i].ed, tbl[i].eo, tbl[i].er));
    end

    // Streaming: one entry per cycle, occupancy pinned at 1
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 4'h1, 5'(i), 32'(i), 32'(i * 16), 1'b1);
      step();
      chk($sformatf("stream%0d", i), act1(), pk(1'b1, 4'h1, 5'(i), 32'(i), 32'(i * 16), 2'd1, 1'b1));
    end
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1);
    step();
    chk("stream_drain", act1(), pk(1'b0, 4'h0, 5'd8, 32'd8, 32'd128, 2'd0, 1'b1));

    // Randomized traffic against queue models of both builds
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 4'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom_range(0, 9) < 6);
      #1;
      rdy1 = (q1.size() < 2);
      rdy0 = out_ready | (q0.size() == 0);
      h1 = (q1.size() > 0) ? q1[0] : last1;
      h0 = (q0.size() > 0) ? q0[0] : last0;
      chk("rand_skid", act1(), exp_from(q1.size(), h1, rdy1));
      chk("rand_noskid", act0(), exp_from(q0.size(), h0, rdy0));
      e = '{c: in_ctrl, w: in_wn, a: in_alu, d: in_qb};
      if (flush) begin
        if (q1.size() > 0) last1 = q1[0];
        if (q0.size() > 0) last0 = q0[0];
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() > 0 && out_ready) last1 = q1.pop_front();
        if (in_valid && rdy1) q1.push_back(e);
        if (q0.size() > 0 && out_ready) last0 = q0.pop_front();
        if (in_valid && rdy0) q0.push_back(e);
      end
      @(posedge clk);
      #1;
    end

    // Single-entry build: in_ready follows out_ready in the same cycle, entry replaced on overlap
    do_reset();
    drive(1'b0, 1'b1, 4'h5, 5'd9, 32'hAB, 32'hCD, 1'b0);
    step();
    chk("noskid_hold", act0(), pk(1'b1, 4'h5, 5'd9, 32'hAB, 32'hCD, 2'd1, 1'b0));
    drive(1'b0, 1'b1, 4'h2, 5'd10, 32'hEF, 32'h12, 1'b1);
    #1;
    chk("noskid_ready_comb", 80'(in_ready0), 80'(1'b1));
    step();
    chk("noskid_replace", act0(), pk(1'b1, 4'h2, 5'd10, 32'hEF, 32'h12, 2'd1, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
